// File: rtl/mem_2_pkg.sv
// mem2_pkg: shared constants and the address-width helper for the mem_2 operand buffer
package mem2_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_VETOR_WIDTH = 4;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_2_if.sv
// mem_2_if: write/read strobe bundle of the mem_2 operand buffer
interface mem_2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] datain;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output wr_en, wr_addr, datain, rd_en, rd_addr, input data_out);
    modport slave  (input wr_en, wr_addr, datain, rd_en, rd_addr, output data_out);

endinterface

// File: rtl/mem_2_array.sv
// mem_2_array: storage array with write port and unregistered read lookup
module mem_2_array #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok   = 32'(wr_addr) < DEPTH;
    assign rd_ok   = 32'(rd_addr) < DEPTH;
    assign rd_data = rd_ok ? mem[rd_addr] : '0;

    // Reset clears only word 0; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (rst)
            mem[0] <= '0;
        else if (wr_en && wr_ok)
            mem[wr_addr] <= datain;
    end

endmodule

// File: rtl/mem_2.sv
// mem_2: 1W/1R synchronous operand RAM with registered read (one-cycle latency)
// Optional macro MEM2_WR_FIRST_EN: same-address read+write returns datain (write-first)
module mem_2
    import mem2_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int VETOR_WIDTH = DEF_VETOR_WIDTH
) (
    input logic     clk,
    input logic     rst,
    mem_2_if.slave  bus
);

    localparam int DEPTH      = VETOR_WIDTH * DATA_WIDTH;
    localparam int ADDR_WIDTH = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] rd_word;

    mem_2_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .datain  (bus.datain),
        .rd_addr (bus.rd_addr),
        .rd_data (rd_data)
    );

`ifdef MEM2_WR_FIRST_EN
    assign rd_word = (bus.wr_en && bus.wr_addr == bus.rd_addr && 32'(bus.rd_addr) < DEPTH)
                     ? bus.datain : rd_data;
`else
    assign rd_word = rd_data;
`endif

    // Read register: cleared by reset, loads on rd_en, otherwise holds
    always_ff @(posedge clk) begin
        if (rst)
            bus.data_out <= '0;
        else if (bus.rd_en)
            bus.data_out <= rd_word;
    end

endmodule

// File: tb/tb_mem_2.sv
// tb_mem_2: scoreboard bench for mem_2 against a read-first reference model
module tb_mem_2;
    import mem2_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out = '0;
    logic [DW-1:0] sb [$];

    always #5 clk = ~clk;

    mem_2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: data_out=0x%02h expected 0x%02h", tag, got, exp);
    endtask

    task automatic step(input string tag, input logic r, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic rd, input logic [AW-1:0] ra);
        logic [DW-1:0] exp;
        rst         = r;
        bus.wr_en   = w;
        bus.wr_addr = wa;
        bus.datain  = wd;
        bus.rd_en   = rd;
        bus.rd_addr = ra;
`ifdef MEM2_WR_FIRST_EN
        exp = r ? '0 : rd ? ((w && wa == ra) ? wd : ref_mem[ra]) : ref_out;
`else
        exp = r ? '0 : rd ? ref_mem[ra] : ref_out;
`endif
        sb.push_back(exp);
        ref_out = exp;
        if (r)
            ref_mem[0] = '0;
        else if (w)
            ref_mem[wa] = wd;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", tag);
        end else
            check(tag, bus.data_out, sb.pop_front());
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step("wr", 1'b0, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b1, a);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.datain = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, '0, '0, 1'b0, '0);
        rd("rd_a0_after_reset", 5'd0);
        wr(5'd0, 8'h11);
        wr(5'd1, 8'h22);
        rd("rd_a0", 5'd0);
        rd("rd_a1", 5'd1);
        wr(5'd1, 8'hA5);
        rd("rd_a1_overwrite", 5'd1);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, '0, '0, 1'b0, '0);
        wr(5'd2, 8'h00);
        step("same_addr_rw", 1'b0, 1'b1, 5'd2, 8'h3C, 1'b1, 5'd2);
        rd("rd_a2_after", 5'd2);
        step("diff_addr_rw", 1'b0, 1'b1, 5'd3, 8'h77, 1'b1, 5'd1);
        rd("rd_a3", 5'd3);
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i) ^ 8'h5A);
        for (int i = 0; i < 16; i++) rd("fill_rd", AW'(i));
        step("mid_reset", 1'b1, 1'b1, 5'd5, 8'hFF, 1'b1, 5'd3);
        rd("rd_a0_cleared", 5'd0);
        rd("rd_a5_kept", 5'd5);
        for (int i = 16; i < DEPTH; i++) rd("fill_rd_post", AW'(i));
        check("a31_value", bus.data_out, 8'h45);
        for (int i = 0; i < 40; i++)
            step("random", 1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                 DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
